vga_sprite_regs: RTL

- Memory-mapped sprite register file between the CPU bus and the VGA sync/colour stage.
- Holds shadow copies of the two sprite positions and 16x16 bitmaps, which the CPU writes.
- Commits shadow to the active outputs only at frame boundaries, marked by a rising edge of the VGA interrupt, so tearing cannot occur.
- Also owns the interrupt acknowledge handshake and a sticky sprite-overlap flag.

---
 rtl/vga_sprite_regs.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/vga_sprite_regs.sv
// Sprite register file: CPU-written shadow positions/bitmaps committed to the active
// outputs on a frame interrupt edge. Also owns the irq acknowledge and a sticky overlap flag.
module vga_sprite_regs #(
  parameter int unsigned H_MAX = 624,
  parameter int unsigned V_MAX = 464
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        addr,
  input  logic [15:0]       data_in,
  input  logic              wr,
  input  logic              rd,
  output logic [15:0]       data_out,
  input  logic              irq,
  output logic              ack,
  output logic [15:0]       spaceship_horizontal,
  output logic [15:0]       spaceship_vertical,
  output logic [15:0]       planet_horizontal,
  output logic [15:0]       planet_vertical,
  output logic [15:0][15:0] spaceship_bitmap,
  output logic [15:0][15:0] planet_bitmap
);

  localparam logic [15:0] HLim = 16'(H_MAX);
  localparam logic [15:0] VLim = 16'(V_MAX);

  typedef enum logic [1:0] {StIdle, StArmed, StCommit} commit_state_e;
  typedef enum logic {AckIdle, AckHigh} ack_state_e;

  commit_state_e cstate_q, cstate_d;
  ack_state_e    astate_q, astate_d;

  logic [15:0]       ship_h_q, ship_h_d, ship_v_q, ship_v_d;
  logic [15:0]       planet_h_q, planet_h_d, planet_v_q, planet_v_d;
  logic [15:0][15:0] ship_bmp_q, ship_bmp_d, planet_bmp_q, planet_bmp_d;

  logic [15:0]       act_ship_h_q, act_ship_h_d, act_ship_v_q, act_ship_v_d;
  logic [15:0]       act_planet_h_q, act_planet_h_d, act_planet_v_q, act_planet_v_d;
  logic [15:0][15:0] act_ship_bmp_q, act_ship_bmp_d, act_planet_bmp_q, act_planet_bmp_d;

  logic        collision_q, collision_d;
  logic        irq_prev_q;
  logic [15:0] data_out_q, data_out_d;

  logic        arm_wr, stat_wr, irq_rise, commit, overlap;
  logic [15:0] dh, dv, rd_data;

  function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  assign arm_wr   = wr && (addr == 8'h04) && data_in[0];
  assign stat_wr  = wr && (addr == 8'h05);
  assign irq_rise = irq && !irq_prev_q;
  assign commit   = (cstate_q == StCommit);

  // Bounding-box overlap on the shadow positions that are about to go live
  always_comb begin
    dh      = (ship_h_q >= planet_h_q) ? ship_h_q - planet_h_q : planet_h_q - ship_h_q;
    dv      = (ship_v_q >= planet_v_q) ? ship_v_q - planet_v_q : planet_v_q - ship_v_q;
    overlap = (dh < 16'd16) && (dv < 16'd16);
  end

  always_comb begin
    ship_h_d     = ship_h_q;
    ship_v_d     = ship_v_q;
    planet_h_d   = planet_h_q;
    planet_v_d   = planet_v_q;
    ship_bmp_d   = ship_bmp_q;
    planet_bmp_d = planet_bmp_q;
    if (wr) begin
      case (addr)
        8'h00:   ship_h_d   = clamp(data_in, HLim);
        8'h01:   ship_v_d   = clamp(data_in, VLim);
        8'h02:   planet_h_d = clamp(data_in, HLim);
        8'h03:   planet_v_d = clamp(data_in, VLim);
        default: ;
      endcase
      if (addr[7:4] == 4'h1) ship_bmp_d[addr[3:0]] = data_in;
      if (addr[7:4] == 4'h2) planet_bmp_d[addr[3:0]] = data_in;
    end
  end

  // Active copies take the pre-write shadow, so a write during commit lands next frame
  always_comb begin
    act_ship_h_d     = act_ship_h_q;
    act_ship_v_d     = act_ship_v_q;
    act_planet_h_d   = act_planet_h_q;
    act_planet_v_d   = act_planet_v_q;
    act_ship_bmp_d   = act_ship_bmp_q;
    act_planet_bmp_d = act_planet_bmp_q;
    if (commit) begin
      act_ship_h_d     = ship_h_q;
      act_ship_v_d     = ship_v_q;
      act_planet_h_d   = planet_h_q;
      act_planet_v_d   = planet_v_q;
      act_ship_bmp_d   = ship_bmp_q;
      act_planet_bmp_d = planet_bmp_q;
    end
  end

  always_comb begin
    collision_d = collision_q;
    if (stat_wr && data_in[1]) collision_d = 1'b0;
    if (commit && overlap)     collision_d = 1'b1;
  end

  always_comb begin
    cstate_d = cstate_q;
    unique case (cstate_q)
      StIdle:   if (arm_wr) cstate_d = StArmed;
      StArmed:  if (irq_rise) cstate_d = StCommit;
      StCommit: cstate_d = arm_wr ? StArmed : StIdle;
      default:  cstate_d = StIdle;
    endcase
  end

  always_comb begin
    astate_d = astate_q;
    unique case (astate_q)
      AckIdle: if (stat_wr && data_in[0] && irq) astate_d = AckHigh;
      AckHigh: if (!irq) astate_d = AckIdle;
      default: astate_d = AckIdle;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      8'h00:   rd_data = ship_h_q;
      8'h01:   rd_data = ship_v_q;
      8'h02:   rd_data = planet_h_q;
      8'h03:   rd_data = planet_v_q;
      8'h05:   rd_data = {13'b0, cstate_q == StArmed, collision_q, irq};
      default: begin
        if (addr[7:4] == 4'h1) rd_data = ship_bmp_q[addr[3:0]];
        if (addr[7:4] == 4'h2) rd_data = planet_bmp_q[addr[3:0]];
      end
    endcase
    data_out_d = rd ? rd_data : data_out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cstate_q         <= StIdle;
      astate_q         <= AckIdle;
      ship_h_q         <= '0;
      ship_v_q         <= '0;
      planet_h_q       <= '0;
      planet_v_q       <= '0;
      ship_bmp_q       <= '0;
      planet_bmp_q     <= '0;
      act_ship_h_q     <= '0;
      act_ship_v_q     <= '0;
      act_planet_h_q   <= '0;
      act_planet_v_q   <= '0;
      act_ship_bmp_q   <= '0;
      act_planet_bmp_q <= '0;
      collision_q      <= 1'b0;
      irq_prev_q       <= 1'b0;
      data_out_q       <= '0;
    end else begin
      cstate_q         <= cstate_d;
      astate_q         <= astate_d;
      ship_h_q         <= ship_h_d;
      ship_v_q         <= ship_v_d;
      planet_h_q       <= planet_h_d;
      planet_v_q       <= planet_v_d;
      ship_bmp_q       <= ship_bmp_d;
      planet_bmp_q     <= planet_bmp_d;
      act_ship_h_q     <= act_ship_h_d;
      act_ship_v_q     <= act_ship_v_d;
      act_planet_h_q   <= act_planet_h_d;
      act_planet_v_q   <= act_planet_v_d;
      act_ship_bmp_q   <= act_ship_bmp_d;
      act_planet_bmp_q <= act_planet_bmp_d;
      collision_q      <= collision_d;
      irq_prev_q       <= irq;
      data_out_q       <= data_out_d;
    end
  end

  assign data_out             = data_out_q;
  assign ack                  = (astate_q == AckHigh);
  assign spaceship_horizontal = act_ship_h_q;
  assign spaceship_vertical   = act_ship_v_q;
  assign planet_horizontal    = act_planet_h_q;
  assign planet_vertical      = act_planet_v_q;
  assign spaceship_bitmap     = act_ship_bmp_q;
  assign planet_bitmap        = act_planet_bmp_q;

endmodule
